// File: rtl/dac_wave_pkg.sv
// Shared types and reset constants for the dac_wave_gen square-wave code generator.
package dac_wave_pkg;

  localparam int CFG_DW    = 16;
  localparam int CFG_CNT_W = 32;

  localparam logic [CFG_CNT_W-1:0] DEF_HALF = 32'd5000;
  localparam logic [CFG_DW-1:0]    DEF_LO   = 16'h03FF;
  localparam logic [CFG_DW-1:0]    DEF_HI   = 16'h4000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } wave_state_e;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] half;
    logic [CFG_DW-1:0]    lo;
    logic [CFG_DW-1:0]    hi;
    logic [CFG_DW-1:0]    step;
    logic                 swap_b;
  } wave_cfg_t;

endpackage

// File: rtl/dac_wave_gen_if.sv
// Config handshake and DAC code bus of dac_wave_gen; master drives config, slave is the generator.
interface dac_wave_gen_if #(
  parameter int DW    = 16,
  parameter int CNT_W = 32
);
  logic             run;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  logic [DW-1:0]    cfg_lo;
  logic [DW-1:0]    cfg_hi;
  logic [DW-1:0]    cfg_step;
  logic             cfg_swap_b;
  logic [DW-1:0]    dac_a;
  logic [DW-1:0]    dac_b;
  logic             phase;
  logic             dac_upd;

  modport master (
    output run, cfg_valid, cfg_half, cfg_lo, cfg_hi, cfg_step, cfg_swap_b,
    input  cfg_ready, dac_a, dac_b, phase, dac_upd
  );

  modport slave (
    input  run, cfg_valid, cfg_half, cfg_lo, cfg_hi, cfg_step, cfg_swap_b,
    output cfg_ready, dac_a, dac_b, phase, dac_upd
  );
endinterface

// File: rtl/dac_slew_limiter.sv
// One DAC channel code register; with DAC_WAVE_SLEW_EN defined the per-clock step is bounded,
// otherwise the code follows its target directly and step is ignored.
module dac_slew_limiter #(
  parameter int            DW      = 16,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] target,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] code,
  output logic [DW-1:0] code_nxt
);

  logic [DW-1:0] code_p1;

`ifdef DAC_WAVE_SLEW_EN
  // Difference is taken one bit wider so the magnitude never wraps.
  function automatic logic [DW-1:0] slew_next(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] tgt,
                                               input logic [DW-1:0] stp);
    logic signed [DW:0] diff;
    logic        [DW:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    if (stp == '0 || mag <= {1'b0, stp}) return tgt;
    else if (diff[DW])                   return cur - stp;
    else                                 return cur + stp;
  endfunction

  assign code_nxt = slew_next(code_p1, target, step);
`else
  logic unused_step;
  assign unused_step = ^step;
  assign code_nxt    = target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) code_p1 <= RST_VAL;
    else        code_p1 <= code_nxt;
  end

  assign code = code_p1;

endmodule

// File: rtl/dac_wave_gen.sv
// Two-channel programmable square-wave DAC code generator with boundary-aligned config updates.
// Optional slew limiting is built when DAC_WAVE_SLEW_EN is defined.
module dac_wave_gen
  import dac_wave_pkg::*;
#(
  parameter int               DW       = dac_wave_pkg::CFG_DW,
  parameter int               CNT_W    = dac_wave_pkg::CFG_CNT_W,
  parameter logic [CNT_W-1:0] DEF_HALF = dac_wave_pkg::DEF_HALF,
  parameter logic [DW-1:0]    DEF_LO   = dac_wave_pkg::DEF_LO,
  parameter logic [DW-1:0]    DEF_HI   = dac_wave_pkg::DEF_HI
) (
  input  logic           clk,
  input  logic           rst_n,
  dac_wave_gen_if.slave  bus
);

  wave_state_e      st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, half_m1;
  wave_cfg_t        act, act_nxt, pend;
  logic             ready_p1, phase_p1, upd_p1;
  logic             at_end, accept, apply;
  logic             lvl_hi;
  logic [DW-1:0]    tgt_a, tgt_b;
  logic [DW-1:0]    code_a, code_b, code_a_nxt, code_b_nxt;

  // A half-period of 0 behaves as 1.
  assign half_m1 = (act.half == '0) ? '0 : act.half - 1'b1;
  assign at_end  = (cnt == half_m1);
  assign accept  = bus.cfg_valid && ready_p1;
  // The slot drains in IDLE, on leaving LOW/HIGH, or at the HIGH->LOW boundary.
  assign apply   = !ready_p1 &&
                   (st == ST_IDLE || !bus.run || (st == ST_HIGH && at_end));

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.run) st_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (!bus.run)    begin st_nxt = ST_IDLE; cnt_nxt = '0; end
        else if (at_end) begin st_nxt = ST_HIGH; cnt_nxt = '0; end
        else             cnt_nxt = cnt + 1'b1;
      end
      ST_HIGH: begin
        if (!bus.run)    begin st_nxt = ST_IDLE; cnt_nxt = '0; end
        else if (at_end) begin st_nxt = ST_LOW;  cnt_nxt = '0; end
        else             cnt_nxt = cnt + 1'b1;
      end
      default: begin
        st_nxt  = ST_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // Targets follow the next state and next config so codes move on the state edge.
  always_comb begin
    act_nxt = apply ? pend : act;
    lvl_hi  = (st_nxt == ST_HIGH);
    tgt_a   = lvl_hi ? act_nxt.hi : act_nxt.lo;
    tgt_b   = (lvl_hi ^ act_nxt.swap_b) ? act_nxt.hi : act_nxt.lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      act      <= '{half: DEF_HALF, lo: DEF_LO, hi: DEF_HI, step: '0, swap_b: 1'b0};
      ready_p1 <= 1'b1;
      phase_p1 <= 1'b0;
      upd_p1   <= 1'b0;
    end else begin
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      act      <= act_nxt;
      phase_p1 <= (st_nxt == ST_HIGH);
      upd_p1   <= (code_a_nxt != code_a) || (code_b_nxt != code_b);
      if (accept)     ready_p1 <= 1'b0;
      else if (apply) ready_p1 <= 1'b1;
    end
  end

  // Pending payload is only meaningful while the slot is marked full.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend <= '{half: bus.cfg_half, lo: bus.cfg_lo, hi: bus.cfg_hi,
                step: bus.cfg_step, swap_b: bus.cfg_swap_b};
    end
  end

  dac_slew_limiter #(.DW(DW), .RST_VAL(DEF_LO)) u_slew_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .target   (tgt_a),
    .step     (act_nxt.step),
    .code     (code_a),
    .code_nxt (code_a_nxt)
  );

  dac_slew_limiter #(.DW(DW), .RST_VAL(DEF_LO)) u_slew_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .target   (tgt_b),
    .step     (act_nxt.step),
    .code     (code_b),
    .code_nxt (code_b_nxt)
  );

  assign bus.cfg_ready = ready_p1;
  assign bus.dac_a     = code_a;
  assign bus.dac_b     = code_b;
  assign bus.phase     = phase_p1;
  assign bus.dac_upd   = upd_p1;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: reset, default waveform, antiphase, boundary config, reset abort, slew.
module tb_dac_wave_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   k;
  int   upd_cnt;

  dac_wave_gen_if #(.DW(16), .CNT_W(32)) bus ();

  dac_wave_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_ph;
    logic        exp_upd;
    logic        chk_upd;
  } vec_t;

  vec_t vec [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (k=%0d): got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int target_k);
    while (k < target_k) tick();
  endtask

  task automatic offer(input logic [31:0] half, input logic [15:0] lo, input logic [15:0] hi,
                       input logic [15:0] step, input logic swap);
    bus.cfg_half   = half;
    bus.cfg_lo     = lo;
    bus.cfg_hi     = hi;
    bus.cfg_step   = step;
    bus.cfg_swap_b = swap;
    bus.cfg_valid  = 1'b1;
  endtask

  initial begin
    logic [15:0] exp_code;
    checks = 0;
    errors = 0;
    k      = 0;

    // half=4, swap_b=1: A low / B high for 4 clocks, then the reverse.
    vec[0]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[4]  = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b1, 1'b1};
    vec[5]  = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[6]  = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[8]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b1, 1'b1};
    vec[13] = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[14] = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[15] = '{1'b1, 16'h4000, 16'h03FF, 1'b1, 1'b0, 1'b1};
    vec[16] = '{1'b1, 16'h03FF, 16'h4000, 1'b0, 1'b1, 1'b1};

    rst_n          = 1'b0;
    bus.run        = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_half   = '0;
    bus.cfg_lo     = '0;
    bus.cfg_hi     = '0;
    bus.cfg_step   = '0;
    bus.cfg_swap_b = 1'b0;
    repeat (3) tick();

    check("rst_dac_a", bus.dac_a, 16'h03FF);
    check("rst_dac_b", bus.dac_b, 16'h03FF);
    check("rst_phase", bus.phase, 0);
    check("rst_ready", bus.cfg_ready, 1);
    check("rst_upd",   bus.dac_upd, 0);

    rst_n   = 1'b1;
    upd_cnt = 0;
    repeat (10) begin
      tick();
      upd_cnt += bus.dac_upd;
    end
    check("idle_upd_count", upd_cnt, 0);
    check("idle_dac_a", bus.dac_a, 16'h03FF);

    // Default waveform: 5000 clocks low, 5000 clocks high.
    bus.run = 1'b1;
    k = 0;
    tick_to(5000);
    check("def_low_end_a",  bus.dac_a, 16'h03FF);
    check("def_low_end_ph", bus.phase, 0);
    tick();
    check("def_high_a",   bus.dac_a, 16'h4000);
    check("def_high_b",   bus.dac_b, 16'h4000);
    check("def_high_ph",  bus.phase, 1);
    check("def_high_upd", bus.dac_upd, 1);
    tick_to(10000);
    check("def_high_end_a", bus.dac_a, 16'h4000);
    tick();
    check("def_wrap_a",   bus.dac_a, 16'h03FF);
    check("def_wrap_ph",  bus.phase, 0);
    check("def_wrap_upd", bus.dac_upd, 1);

    bus.run = 1'b0;
    tick();
    check("park_a",  bus.dac_a, 16'h03FF);
    check("park_ph", bus.phase, 0);

    // Config in IDLE applies on the following edge.
    offer(32'd4, 16'h03FF, 16'h4000, 16'h0000, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
    check("idle_cfg_ready_low", bus.cfg_ready, 0);
    tick();
    check("idle_cfg_ready_high", bus.cfg_ready, 1);

    k = 0;
    for (int i = 0; i < 17; i++) begin
      bus.run = vec[i].run;
      tick();
      check("vec_dac_a", bus.dac_a, vec[i].exp_a);
      check("vec_dac_b", bus.dac_b, vec[i].exp_b);
      check("vec_phase", bus.phase, vec[i].exp_ph);
      if (vec[i].chk_upd) check("vec_upd", bus.dac_upd, vec[i].exp_upd);
    end

    // Mid-LOW offer (k=17 LOW, count 0); a second offer stalls behind it.
    offer(32'd4, 16'h03FF, 16'h2000, 16'h0000, 1'b1);
    tick();
    check("mid_ready_fall", bus.cfg_ready, 0);
    offer(32'd4, 16'h03FF, 16'h1234, 16'h0000, 1'b1);
    while (k < 24) begin
      tick();
      check("mid_ready_held", bus.cfg_ready, 0);
      if (k == 21) check("mid_old_hi", bus.dac_a, 16'h4000);
    end
    tick();
    check("mid_boundary_a", bus.dac_a, 16'h03FF);
    check("mid_ready_rise", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b0;
    tick_to(29);
    check("mid_new_hi_a", bus.dac_a, 16'h2000);
    check("mid_new_hi_b", bus.dac_b, 16'h03FF);
    check("mid_new_hi_ph", bus.phase, 1);
    tick_to(37);
    check("mid_stalled_not_taken", bus.dac_a, 16'h2000);

    // Transfer coincident with the HIGH->LOW edge at k=41 waits a full period.
    tick_to(40);
    offer(32'd4, 16'h03FF, 16'h3000, 16'h0000, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
    check("bnd_ready_fall", bus.cfg_ready, 0);
    check("bnd_low_a", bus.dac_a, 16'h03FF);
    tick_to(45);
    check("bnd_still_old_hi", bus.dac_a, 16'h2000);
    tick_to(49);
    check("bnd_ready_rise", bus.cfg_ready, 1);
    tick_to(53);
    check("bnd_new_hi", bus.dac_a, 16'h3000);

    // Reset mid-HIGH with a pending config.
    offer(32'd4, 16'h03FF, 16'h1111, 16'h0000, 1'b1);
    tick();
    bus.cfg_valid = 1'b0;
    check("rh_ready_fall", bus.cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rh_dac_a",  bus.dac_a, 16'h03FF);
    check("rh_dac_b",  bus.dac_b, 16'h03FF);
    check("rh_phase",  bus.phase, 0);
    check("rh_ready",  bus.cfg_ready, 1);
    check("rh_upd",    bus.dac_upd, 0);
    tick();
    rst_n = 1'b1;
    k = 0;
    tick_to(5000);
    check("rh_def_low_a",  bus.dac_a, 16'h03FF);
    check("rh_def_low_ph", bus.phase, 0);
    tick();
    check("rh_def_high_a", bus.dac_a, 16'h4000);
    check("rh_def_high_b", bus.dac_b, 16'h4000);

    // Half-period 0 behaves as 1: toggles every clock.
    bus.run = 1'b0;
    tick();
    offer(32'd0, 16'h0010, 16'h0020, 16'h0000, 1'b0);
    tick();
    bus.cfg_valid = 1'b0;
    tick();
    check("h0_idle_a", bus.dac_a, 16'h0010);
    bus.run = 1'b1;
    k = 0;
    tick();
    check("h0_low_a",   bus.dac_a, 16'h0010);
    check("h0_low_ph",  bus.phase, 0);
    tick();
    check("h0_high_a",  bus.dac_a, 16'h0020);
    check("h0_high_ph", bus.phase, 1);
    check("h0_high_upd", bus.dac_upd, 1);
    tick();
    check("h0_low2_a",  bus.dac_a, 16'h0010);
    check("h0_low2_upd", bus.dac_upd, 1);

    // Step 0x0100 between 03FF and 4000, half=100.
    bus.run = 1'b0;
    tick();
    offer(32'd100, 16'h03FF, 16'h4000, 16'h0100, 1'b0);
    tick();
    bus.cfg_valid = 1'b0;
    repeat (10) tick();
    check("sl_idle_a", bus.dac_a, 16'h03FF);
    bus.run = 1'b1;
    k = 0;
    tick_to(100);
    check("sl_low_a", bus.dac_a, 16'h03FF);
`ifdef DAC_WAVE_SLEW_EN
    upd_cnt = 0;
    for (int j = 1; j <= 61; j++) begin
      tick();
      exp_code = (j == 61) ? 16'h4000 : 16'(16'h03FF + j * 16'h0100);
      check("sl_rise_a", bus.dac_a, exp_code);
      check("sl_rise_b", bus.dac_b, exp_code);
      upd_cnt += bus.dac_upd;
    end
    check("sl_rise_upd_count", upd_cnt, 61);
    tick();
    check("sl_rise_settled_upd", bus.dac_upd, 0);
    check("sl_rise_settled_a", bus.dac_a, 16'h4000);
    tick_to(200);
    for (int j = 1; j <= 61; j++) begin
      tick();
      exp_code = (j == 61) ? 16'h03FF : 16'(16'h4000 - j * 16'h0100);
      check("sl_fall_a", bus.dac_a, exp_code);
    end
`else
    tick();
    check("nosl_jump_a", bus.dac_a, 16'h4000);
    check("nosl_jump_upd", bus.dac_upd, 1);
    tick();
    check("nosl_hold_upd", bus.dac_upd, 0);
    tick_to(200);
    tick();
    check("nosl_drop_a", bus.dac_a, 16'h03FF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_wave_gen.md
# dac_wave_gen

Programmable two-channel square-wave code generator. It sits directly upstream of the parallel DAC output stage and drives that stage's 16-bit DA/DB code buses. Low level, high level and half-period are runtime-configurable through a valid/ready config port, and updates apply only on period boundaries. An optional slew limiter bounds the code step per clock on each channel.

## Interface
- `DW`, 16, DAC code width
- `CNT_W`, 32, half-period counter width
- `DEF_HALF`, 5000, reset half-period in clocks
- `DEF_LO`, 16'h03FF, reset low code
- `DEF_HI`, 16'h4000, reset high code

Ports:
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = generate waveform, 0 = park at low level
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config slot free
- `cfg_half`  in  CNT_W  half-period in clocks; 0 is treated as 1
- `cfg_lo`  in  DW  low code
- `cfg_hi`  in  DW  high code
- `cfg_step`  in  DW  max code change per clock; 0 = unlimited
- `cfg_swap_b`  in  1  1 = channel B uses swapped levels (antiphase)
- `dac_a`  out  DW  channel A code
- `dac_b`  out  DW  channel B code
- `phase`  out  1  0 = LOW half, 1 = HIGH half
- `dac_upd`  out  1  pulses in any cycle where `dac_a` or `dac_b` changed

## Operation
- Reset values:
  - Outputs: `dac_a`=`dac_b`=DEF_LO, `phase`=0, `dac_upd`=0, `cfg_ready`=1.
  - Internal: active config = defaults with step 0 and swap 0; pending slot empty; counter 0; state IDLE.
- States:
  - IDLE: target is lo, counter held at 0. When `run`=1, go to LOW.
  - LOW: counter increments. When count = half-1, counter clears and state goes to HIGH.
  - HIGH: same counting rule. When count = half-1, counter clears, state goes to LOW, and the pending config (if any) is applied.
  - From LOW or HIGH, `run`=0 forces IDLE on the next edge. The counter clears and any pending config is applied.
- Config handshake:
  - A transfer occurs when `cfg_valid`=1 and `cfg_ready`=1; it fills the single pending slot.
  - `cfg_ready` is 0 while the slot is full.
  - In IDLE, pending config becomes active on the edge after acceptance.
  - A transfer on the same edge as a HIGH→LOW boundary stays pending until the next boundary.
- Channel targets:
  - A target = hi in HIGH, lo otherwise.
  - B target = A target, or the swapped level when `swap_b`=1.
- Update rule, per channel, each cycle:
  - step = 0 or slew disabled: code ← target.
  - Otherwise, with diff = |target − code| computed in DW+1 bits: code ← target if diff ≤ step, else code ± step. No wrap-around is possible.
- `phase` is the registered state bit (HIGH = 1).

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `dac_a` reflects the new target on the same edge that the state changes (step = 0). The first HIGH code appears 1 clock after the LOW count reaches half-1.
- Period is exactly 2·half clocks. The `run` rise to first LOW cycle takes 1 clock.
- `cfg_ready` falls the clock after acceptance and rises the clock after the slot is applied.
- Changing a level in config never disturbs the current half-period.

## Configuration
- `DAC_WAVE_SLEW_EN` defined: slew limiting per the update rule above.
- Not defined: `cfg_step` is ignored and no slew logic is built. Codes jump to target in one clock; `dac_upd` behaviour is unchanged.

## Structure
- Package `dac_wave_pkg` holds:
  - the state enum (IDLE/LOW/HIGH);
  - the config record type (half, lo, hi, step, swap_b);
  - the DEF_* constants.
- Sub-module `dac_slew_limiter` (one per channel) contains the code register and the step/clamp logic. Its internals are excluded when `DAC_WAVE_SLEW_EN` is absent.

## Test plan
- Reset, `run`=0 → `dac_a`=`dac_b`=16'h03FF, `phase`=0, `cfg_ready`=1, no `dac_upd` pulses.
- Defaults, `run`=1 → `dac_a` alternates 03FF/4000 every 5000 clocks; period 10000; `dac_b`=`dac_a`.
- Config half=4, swap_b=1, step=0 → `dac_b` is the inverse of `dac_a` with an 8-clock period; `dac_upd` pulses every 4 clocks.
- Slew enabled, step=16'h0100, LOW→HIGH from 03FF to 4000 → 61 clocks of rising codes with final value 4000; the run-down mirrors this.
- Config offered mid-LOW with new hi=16'h2000 → old hi holds for the current HIGH half; new hi is used from the next HIGH half; `cfg_ready` stays 0 until the boundary; a second offer is stalled.
- `rst_n` asserted mid-HIGH with a pending config → outputs return to DEF_LO immediately, the pending config is discarded, and defaults resume after release.
